seq_detect_fsm: RTL

SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_detect_fsm_if.sv | 23 ++
 rtl/seq_detect_fsm_next.sv | 28 ++
 rtl/seq_detect_fsm.sv | 51 +++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared constants and border-length helper for the serial pattern detector
package seq_detect_pkg;
  localparam int W_MAX = 8;
  localparam logic [3:0] PAT_INIT_DEF = 4'b1011;
  // Longest proper border of the low w bits of p; bits above w must be zero.
  function automatic int border_len(input logic [W_MAX-1:0] p, input int w);
    logic [W_MAX-1:0] m;
    border_len = 0;
    for (int l = 1; l < W_MAX; l++) begin
      m = W_MAX'((1 << l) - 1);
      if (l < w && ((p >> (w - l)) & m) == (p & m)) border_len = l;
    end
  endfunction
endpackage

// File: rtl/seq_detect_fsm_if.sv
// seq_detect_if: stimulus and result bundle of the serial pattern detector
interface seq_detect_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic                 i_en;
  logic                 i_din;
  logic                 i_load;
  logic [W-1:0]         i_pattern;
  logic                 i_overlap;
  logic [$clog2(W)-1:0] o_state;
  logic                 o_match_mealy;
  logic                 o_match_moore;
  logic [CNT_W-1:0]     o_match_count;
  modport master (
    output i_en, i_din, i_load, i_pattern, i_overlap,
    input  o_state, o_match_mealy, o_match_moore, o_match_count
  );
  modport slave (
    input  i_en, i_din, i_load, i_pattern, i_overlap,
    output o_state, o_match_mealy, o_match_moore, o_match_count
  );
endinterface

// File: rtl/seq_detect_fsm_next.sv
// seq_next_state: combinational KMP transition from matched-prefix length k and one input bit
module seq_next_state
  import seq_detect_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [$clog2(W)-1:0] i_k,
  input  logic                 i_din,
  input  logic [W-1:0]         i_pat,
  input  logic                 i_overlap,
  output logic [$clog2(W)-1:0] o_next_k,
  output logic                 o_hit
);
  localparam int KW = $clog2(W);
  logic [KW-1:0] w_border;
  logic [W:0]    w_cand;
  int            w_best;
  assign w_border = KW'(border_len(W_MAX'(i_pat), W));
  // w_cand is the matched prefix followed by din, right-aligned; pick its longest suffix that is a prefix
  always_comb begin
    w_cand = (({1'b0, i_pat} >> (W - int'(i_k))) << 1) | (W+1)'(i_din);
    w_best = 0;
    for (int l = 1; l <= W; l++)
      if (l <= int'(i_k) + 1 && (w_cand & (W+1)'((1 << l) - 1)) == ({1'b0, i_pat} >> (W - l))) w_best = l;
    o_hit    = (w_best == W);
    o_next_k = o_hit ? (i_overlap ? w_border : '0) : KW'(w_best);
  end
endmodule

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: loadable serial pattern detector with KMP fallback, Mealy/Moore match and saturating count
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int           W        = 4,
  parameter int           CNT_W    = 8,
  parameter logic [W-1:0] PAT_INIT = W'(PAT_INIT_DEF)
) (
  input logic         i_clk,
  input logic         i_rst_n,
  seq_detect_if.slave i_bus
);
  localparam int KW = $clog2(W);
  localparam logic [KW-1:0] K_IDLE = '0;
  logic [KW-1:0]    r_k;
  logic [W-1:0]     r_pat;
  logic [CNT_W-1:0] r_cnt;
  logic             r_moore;
  logic [KW-1:0]    w_next_k;
  logic             w_hit;
  logic             w_mealy;
  seq_next_state #(.W(W)) u_next (
    .i_k      (r_k),
    .i_din    (i_bus.i_din),
    .i_pat    (r_pat),
    .i_overlap(i_bus.i_overlap),
    .o_next_k (w_next_k),
    .o_hit    (w_hit)
  );
  assign w_mealy = i_rst_n & i_bus.i_en & ~i_bus.i_load & w_hit;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_k     <= K_IDLE;
      r_pat   <= PAT_INIT;
      r_cnt   <= '0;
      r_moore <= 1'b0;
    end else if (i_bus.i_load) begin
      r_k     <= K_IDLE;
      r_pat   <= i_bus.i_pattern;
      r_cnt   <= '0;
      r_moore <= 1'b0;
    end else begin
      r_moore <= w_mealy;
      if (i_bus.i_en) r_k <= w_next_k;
      if (w_mealy && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end
  assign i_bus.o_state       = r_k;
  assign i_bus.o_match_mealy = w_mealy;
  assign i_bus.o_match_moore = r_moore;
  assign i_bus.o_match_count = r_cnt;
endmodule
